// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM burst read path.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int unsigned FIFO_DEPTH_MIN = 3;
  localparam int unsigned RD_LATENCY     = 2;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with empty flag and occupancy count; head word is
// presented directly and held until popped.
module sync_fifo_flags
  import bram_rd_pkg::*;
#(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = clogb2(DEPTH + 1),
  localparam int unsigned PTR_W = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push_i && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/bram_burst_rd_ctrl.sv
// Burst read controller for a 2-cycle-latency BRAM port; credits reserve
// FIFO space before each issue since the BRAM pipeline cannot stall.
module bram_burst_rd_ctrl
  import bram_rd_pkg::*;
#(
  parameter int unsigned NUM_COL    = 16,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned LEN_WIDTH  = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned WIDTH  = NUM_COL * COL_WIDTH,
  localparam int unsigned ADDR_W = clogb2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_en_o,
  output logic [NUM_COL-1:0]   mem_we_o,
  output logic                 mem_oreg_en_o,
  output logic                 mem_rst_o,
  input  logic [WIDTH-1:0]     mem_dout_i,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);

  localparam int unsigned CNT_W = clogb2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < FIFO_DEPTH_MIN) begin : g_depth_chk
    $error("bram_burst_rd_ctrl: FIFO_DEPTH must be at least 3");
  end

  rd_state_e              state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic                   done_q, done_d;
  logic [RD_LATENCY-1:0]  pipe_v_q, pipe_v_d;
  logic [RD_LATENCY-1:0]  pipe_last_q, pipe_last_d;

  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic [WIDTH:0]         fifo_head;
  int unsigned            inflight;
  logic                   issue;
  logic                   last_hs;

  // Issue only when every outstanding read already has a FIFO slot reserved.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight = inflight + 32'(pipe_v_q[i]);
    end
    issue = (state_q == ISSUE) && (rem_q != '0) &&
            ((32'(fifo_count) + inflight) < FIFO_DEPTH);
    last_hs = (state_q == DRAIN) && m_valid_o && m_last_o && m_ready_i;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    pipe_v_d    = {pipe_v_q[RD_LATENCY-2:0], issue};
    pipe_last_d = {pipe_last_q[RD_LATENCY-2:0], issue && (rem_q == LEN_WIDTH'(1))};
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d = base_addr_i;
          rem_d  = len_i;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      pipe_v_q    <= '0;
      pipe_last_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      pipe_v_q    <= pipe_v_d;
      pipe_last_q <= pipe_last_d;
    end
  end

  sync_fifo_flags #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (pipe_v_q[RD_LATENCY-1]),
    .data_i  ({pipe_last_q[RD_LATENCY-1], mem_dout_i}),
    .pop_i   (m_ready_i),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q || last_hs;
  assign mem_addr_o    = addr_q;
  assign mem_en_o      = issue;
  assign mem_we_o      = '0;
  assign mem_oreg_en_o = pipe_v_q[0];
  assign mem_rst_o     = ~rstn;
  assign m_valid_o     = ~fifo_empty;
  assign m_data_o      = fifo_head[WIDTH-1:0];
  assign m_last_o      = fifo_head[WIDTH];

endmodule

// File: tb/tb_bram_burst_rd_ctrl.sv
// Directed bench for bram_burst_rd_ctrl with a 2-cycle BRAM read model.
module tb_bram_burst_rd_ctrl;

  localparam int unsigned NUM_COL   = 16;
  localparam int unsigned WIDTH     = 128;
  localparam int unsigned DEPTH     = 2048;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned LEN_WIDTH = 12;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start_i;
  logic [ADDR_W-1:0]    base_addr_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic                 busy_o, done_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 mem_en_o, mem_oreg_en_o, mem_rst_o;
  logic [NUM_COL-1:0]   mem_we_o;
  logic [WIDTH-1:0]     mem_dout_i;
  logic [WIDTH-1:0]     m_data_o;
  logic                 m_valid_o, m_last_o, m_ready_i;

  bram_burst_rd_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .len_i         (len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .mem_addr_o    (mem_addr_o),
    .mem_en_o      (mem_en_o),
    .mem_we_o      (mem_we_o),
    .mem_oreg_en_o (mem_oreg_en_o),
    .mem_rst_o     (mem_rst_o),
    .mem_dout_i    (mem_dout_i),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_last_o      (m_last_o),
    .m_ready_i     (m_ready_i)
  );

  always #5 clk = ~clk;

  // BRAM model: address latch on en, output register on oreg_en.
  logic [WIDTH-1:0] ram [DEPTH];
  logic [WIDTH-1:0] ram_lat;
  always @(posedge clk) begin
    if (mem_en_o) ram_lat <= ram[mem_addr_o];
    if (mem_rst_o) mem_dout_i <= '0;
    else if (mem_oreg_en_o) mem_dout_i <= ram_lat;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor sampled on the falling edge.
  logic [WIDTH-1:0]  q_data[$];
  logic              q_last[$];
  int                q_cyc[$];
  logic [ADDR_W-1:0] q_addr[$];
  int en_cnt, done_cnt, done_cyc, first_valid_cyc;
  logic prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic prev_last;

  task automatic clear_mon();
    q_data.delete(); q_last.delete(); q_cyc.delete(); q_addr.delete();
    en_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (prev_stall) begin
        check_eq("stall_data_stable", m_data_o, prev_data);
        check_eq("stall_last_stable", 128'(m_last_o), 128'(prev_last));
      end
      if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid_o && m_ready_i) begin
        q_data.push_back(m_data_o);
        q_last.push_back(m_last_o);
        q_cyc.push_back(cyc);
      end
      if (mem_en_o) begin
        en_cnt++;
        q_addr.push_back(mem_addr_o);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid_o && !m_ready_i;
    end else begin
      prev_stall = 1'b0;
    end
    prev_data = m_data_o;
    prev_last = m_last_o;
  end

  int start_cyc;

  task automatic start_burst(input int base, input int len);
    base_addr_i = ADDR_W'(base);
    len_i       = LEN_WIDTH'(len);
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input int want);
    int k;
    for (k = 0; k < 300; k++) begin
      if (done_cnt >= want) break;
      @(posedge clk);
      #1;
    end
    if (k == 300) check_eq("done_timeout", 128'(done_cnt), 128'(want));
  endtask

  task automatic check_words(input string tag, input int base, input int n);
    logic [WIDTH-1:0] d;
    logic l;
    check_eq({tag, "_count"}, 128'(q_data.size()), 128'(n));
    for (int i = 0; i < n; i++) begin
      d = (i < q_data.size()) ? q_data[i] : 'x;
      l = (i < q_last.size()) ? q_last[i] : 1'bx;
      check_eq({tag, "_data"}, d, 128'((base + i) % DEPTH));
      check_eq({tag, "_last"}, 128'(l), 128'(i == n - 1));
    end
  endtask

  task automatic check_addrs(input string tag, input int base, input int n);
    logic [ADDR_W-1:0] a;
    check_eq({tag, "_issues"}, 128'(en_cnt), 128'(n));
    for (int i = 0; i < n; i++) begin
      a = (i < q_addr.size()) ? q_addr[i] : 'x;
      check_eq({tag, "_addr"}, 128'(a), 128'((base + i) % DEPTH));
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = WIDTH'(i);
    prev_stall = 1'b0;
    clear_mon();
    rstn = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 128'(busy_o), 0);
    check_eq("rst_done", 128'(done_o), 0);
    check_eq("rst_en", 128'(mem_en_o), 0);
    check_eq("rst_oreg", 128'(mem_oreg_en_o), 0);
    check_eq("rst_valid", 128'(m_valid_o), 0);
    check_eq("rst_last", 128'(m_last_o), 0);
    check_eq("rst_addr", 128'(mem_addr_o), 0);
    check_eq("rst_memrst", 128'(mem_rst_o), 1);
    check_eq("rst_we", 128'(mem_we_o), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("run_memrst", 128'(mem_rst_o), 0);

    // 1: basic burst, full throughput
    clear_mon();
    start_burst(5, 8);
    check_eq("t1_busy", 128'(busy_o), 1);
    wait_done(1);
    check_words("t1", 5, 8);
    check_addrs("t1", 5, 8);
    check_eq("t1_first_valid", 128'(first_valid_cyc - start_cyc), 3);
    check_eq("t1_done_lat", 128'(done_cyc - start_cyc), 10);
    check_eq("t1_gapless", 128'(q_cyc.size() == 8 ? q_cyc[7] - q_cyc[0] : -1), 7);
    check_eq("t1_done_cnt", 128'(done_cnt), 1);
    check_eq("t1_idle", 128'(busy_o), 0);

    // 2: address wrap
    clear_mon();
    start_burst(2046, 4);
    wait_done(1);
    check_addrs("t2", 2046, 4);
    check_words("t2", 2046, 4);
    check_eq("t2_gapless", 128'(q_cyc.size() == 4 ? q_cyc[3] - q_cyc[0] : -1), 3);

    // 3: backpressure limited by credits
    clear_mon();
    m_ready_i = 1'b0;
    start_burst(0, 8);
    repeat (9) @(posedge clk);
    #1;
    check_eq("t3_issues_stalled", 128'(en_cnt), 4);
    check_eq("t3_en_low", 128'(mem_en_o), 0);
    check_eq("t3_valid", 128'(m_valid_o), 1);
    check_eq("t3_head", m_data_o, 0);
    m_ready_i = 1'b1;
    wait_done(1);
    check_words("t3", 0, 8);
    check_addrs("t3", 0, 8);

    // 4: zero-length burst
    clear_mon();
    start_burst(77, 0);
    check_eq("t4_done", 128'(done_o), 1);
    check_eq("t4_busy", 128'(busy_o), 0);
    @(posedge clk);
    #1;
    check_eq("t4_done_pulse", 128'(done_o), 0);
    check_eq("t4_no_issue", 128'(en_cnt), 0);
    check_eq("t4_no_valid", 128'(first_valid_cyc), 128'(-1));
    check_eq("t4_done_cnt", 128'(done_cnt), 1);

    // 5: reset mid-burst, then a fresh burst
    clear_mon();
    start_burst(100, 8);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_issued", 128'(en_cnt), 3);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_valid", 128'(m_valid_o), 0);
    check_eq("t5_busy", 128'(busy_o), 0);
    check_eq("t5_done", 128'(done_o), 0);
    check_eq("t5_en", 128'(mem_en_o), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t5_no_done", 128'(done_cnt), 0);
    clear_mon();
    start_burst(200, 2);
    wait_done(1);
    check_words("t5", 200, 2);
    check_addrs("t5", 200, 2);

    // 6: start during ISSUE is ignored
    clear_mon();
    start_burst(300, 6);
    @(posedge clk);
    #1;
    start_burst(50, 3);
    wait_done(1);
    check_addrs("t6", 300, 6);
    check_words("t6", 300, 6);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_done_cnt", 128'(done_cnt), 1);
    check_eq("t6_idle", 128'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
